// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial sequence detector.
//   state_t    : controller FSM state encoding (IDLE, ARMED, DONE)
//   DEF_PAT_W  : default maximum pattern length in bits
//   DEF_CNT_W  : default match counter / limit width
//   clamp_len  : maps a requested length onto 1..pat_w
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;

  // Length 0 would compare nothing, so it behaves as a 1-bit pattern.
  function automatic int clamp_len(input int len, input int pat_w);
    if (len == 0)     return 1;
    if (len > pat_w)  return pat_w;
    return len;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and pattern compare.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clears history and fill (arm)
//   shift_en  : accept bit i this cycle
//   i         : serial data bit, enters history bit 0
//   pattern   : latched pattern, bit len-1 is the oldest bit
//   len       : latched, already clamped length (1..PAT_W)
//   hit       : combinational; the bit being shifted in completes a match
// Macro SEQ_DETECT_OVERLAP_EN: keep fill after a hit so overlapping
// matches are found; otherwise fill restarts at 0 after a hit.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter  int PAT_W = DEF_PAT_W,
  localparam int LW    = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             i,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LW-1:0]    len,
  output logic             hit
);

  logic [PAT_W-1:0] hist, hist_nxt, mask;
  logic [LW-1:0]    fill, fill_nxt;

  // Compare against the post-shift history so the pulse follows the
  // completing bit by exactly one register stage.
  always_comb begin
    hist_nxt = {hist[PAT_W-2:0], i};
    fill_nxt = (fill == LW'(PAT_W)) ? fill : fill + LW'(1);
    mask     = '0;
    for (int k = 0; k < PAT_W; k++)
      mask[k] = (k < int'(len));
    hit = shift_en && ((hist_nxt & mask) == (pattern & mask)) && (fill_nxt >= len);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_nxt;
`ifdef SEQ_DETECT_OVERLAP_EN
      fill <= fill_nxt;
`else
      fill <= hit ? '0 : fill_nxt;
`endif
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial sequence detector controller: IDLE/ARMED/DONE FSM, config
// latch, match counter with optional limit, and a single-entry event
// register with valid/ready handshake and sticky overflow.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i, i_valid          : serial data bit and its qualifier
//   cfg_we, cfg_pattern, cfg_len, cfg_limit : config write (IDLE only)
//   arm, disarm         : start detection / abort to IDLE (disarm wins)
//   evt_ready           : consumer accepts the pending event
//   out                 : one-cycle match pulse
//   busy, done          : state is ARMED / DONE
//   match_count         : matches since last arm, saturating
//   evt_valid, evt_count: pending event and its captured count
//   overflow            : sticky, an event was dropped
//   cfg_err             : one-cycle pulse, cfg_we rejected
// Macro SEQ_DETECT_OVERLAP_EN (in seq_match_core): overlapping matches.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter  int PAT_W = DEF_PAT_W,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int LW    = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i,
  input  logic             i_valid,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             arm,
  input  logic             disarm,
  input  logic             evt_ready,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic             cfg_err
);

  state_t           state;
  logic [PAT_W-1:0] pattern;
  logic [LW-1:0]    len;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt_inc;
  logic             arm_go, shift_en, hit;

  // arm only takes effect from IDLE/DONE; disarm suppresses both arm and
  // shifting so an aborting cycle never produces a pulse.
  assign arm_go   = arm && !disarm && (state != ARMED);
  assign shift_en = i_valid && (state == ARMED) && !disarm;
  assign cnt_inc  = (match_count == '1) ? match_count : match_count + CNT_W'(1);
  assign busy     = (state == ARMED);
  assign done     = (state == DONE);

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (arm_go),
    .shift_en (shift_en),
    .i        (i),
    .pattern  (pattern),
    .len      (len),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pattern     <= '0;
      len         <= LW'(1);
      limit       <= '0;
      out         <= 1'b0;
      match_count <= '0;
      evt_valid   <= 1'b0;
      evt_count   <= '0;
      overflow    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      out     <= 1'b0;
      cfg_err <= 1'b0;

      if (evt_valid && evt_ready)
        evt_valid <= 1'b0;

      if (cfg_we) begin
        if (state == IDLE) begin
          pattern <= cfg_pattern;
          len     <= LW'(clamp_len(int'(cfg_len), PAT_W));
          limit   <= cfg_limit;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      if (disarm) begin
        state <= IDLE;
      end else if (arm_go) begin
        state       <= ARMED;
        match_count <= '0;
        overflow    <= 1'b0;
        evt_valid   <= 1'b0;
      end else if (hit) begin
        out         <= 1'b1;
        match_count <= cnt_inc;
        // A slot freed by this cycle's handshake can take the new event.
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_count <= cnt_inc;
        end else begin
          overflow <= 1'b1;
        end
        if ((limit != '0) && (cnt_inc == limit))
          state <= DONE;
      end
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter PAT_W, default 8, maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8, width of the match counter and the match limit.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i  input  1  serial data bit.
REQ-006 i_valid  input  1  i is sampled only when high.
REQ-007 cfg_we  input  1  configuration write strobe.
REQ-008 cfg_pattern  input  PAT_W  pattern; bit len-1 arrives first, bit 0 arrives last.
REQ-009 cfg_len  input  $clog2(PAT_W)+1  pattern length.
REQ-010 cfg_limit  input  CNT_W  matches before DONE; 0 means unlimited.
REQ-011 arm  input  1  start detection.
REQ-012 disarm  input  1  abort to IDLE.
REQ-013 evt_ready  input  1  consumer accepts event.
REQ-014 out  output  1  one-cycle match pulse.
REQ-015 busy  output  1  high in ARMED.
REQ-016 done  output  1  high in DONE.
REQ-017 match_count  output  CNT_W  matches since last arm.
REQ-018 evt_valid  output  1  match event pending.
REQ-019 evt_count  output  CNT_W  match_count value captured with the event.
REQ-020 overflow  output  1  sticky flag: an event was lost.
REQ-021 cfg_err  output  1  one-cycle pulse: cfg_we was rejected.

Function
REQ-022 FSM states and transitions:
- IDLE -> ARMED on arm.
- ARMED -> DONE on the match that makes match_count equal cfg_limit (cfg_limit non-zero).
- DONE -> ARMED on arm.
- Any state -> IDLE on disarm.
REQ-023 disarm and arm in the same cycle: disarm wins.
REQ-024 cfg_we handling:
- Accepted only in IDLE, latching pattern, len and limit.
- Ignored in any other state, with a cfg_err pulse in the next cycle.
REQ-025 Latched len 0 is treated as 1; len greater than PAT_W is clamped to PAT_W.
REQ-026 On arm, in the same edge, clear the history, fill count, match_count, overflow and evt_valid.
REQ-027 Shifting in ARMED: on each i_valid cycle, the history shifts left with i entering bit 0, and fill increments, saturating at PAT_W.
REQ-028 A match is history[len-1:0] equal to pattern[len-1:0] with fill at least len, evaluated on the updated history.
REQ-029 out is registered: it pulses high exactly one cycle after the i_valid edge that completes a match, and never while in IDLE or DONE.
REQ-030 On a match, match_count increments, saturating at all-ones.
REQ-031 On a match with no event pending, evt_valid rises together with out, and evt_count takes the new match_count.
REQ-032 Event handshake:
- evt_valid holds, with evt_count stable, until a cycle with evt_valid and evt_ready both high; it clears after that cycle.
- A match in the same cycle as that handshake loads the new event, and overflow does not set.
REQ-033 A match while evt_valid is high and evt_ready is low sets overflow; the pending event is kept unchanged.
REQ-034 i_valid is ignored outside ARMED, and the history is frozen there.

Reset
REQ-035 Reset values:
- State IDLE.
- History, fill and match_count 0.
- out, evt_valid, evt_count, overflow and cfg_err 0.
- Pattern 0, len 1, limit 0.
REQ-036 rst mid-operation overrides arm, disarm and cfg_we in that cycle, and drops any pending event.

Configuration
REQ-037 SEQ_DETECT_OVERLAP_EN defined: after a match, the history and fill are kept, so overlapping matches are detected.
REQ-038 SEQ_DETECT_OVERLAP_EN undefined: after a match, fill is cleared to 0, so the next match needs len fresh bits.

Structure
REQ-039 Package seq_detect_pkg holds:
- The state enum typedef (IDLE, ARMED, DONE).
- Default PAT_W and CNT_W constants.
- A len-clamp function.
REQ-040 Sub-module seq_match_core holds the history shift register, fill counter and compare, and outputs a combinational hit.

Verification
REQ-041 Pattern 1011, len 4, limit 0, no overlap; arm; stream 1,0,1,1,0,1,1 -> one out pulse, one cycle after the 4th bit; match_count 1.
REQ-042 Same stream with SEQ_DETECT_OVERLAP_EN -> pulses after bits 4 and 7; match_count 2.
REQ-043 Pattern 11, len 2, limit 3; stream of six 1s with overlap enabled and evt_ready held high -> three pulses; done high after the third; busy low.
REQ-044 evt_ready low, two matches -> evt_valid stays high with evt_count 1, and overflow sets on the second match; evt_ready high one cycle -> evt_valid drops.
REQ-045 cfg_we while ARMED -> cfg_err pulses and the pattern is unchanged; arm and disarm together -> IDLE.
REQ-046 rst asserted mid-stream with evt_valid high -> all outputs at reset values on the next cycle.
